// File: rtl/ic_7458_tester_pkg.sv
// Shared types and sizing for the 7458 exhaustive tester.
package ic_tester_pkg;
  localparam int VEC_W      = 10;
  localparam int NUM_VEC    = 1024;
  localparam int ERR_W      = 11;
  localparam int SETTLE_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/ic_7458_tester_if.sv
// Tester <-> device/controller bundle. The first-fail capture ports exist
// only when IC7458_TESTER_FAIL_LOG_EN is defined.
interface ic_7458_tester_if;
  import ic_tester_pkg::*;
  logic             start;
  logic             p1a, p1b, p1c, p1d, p1e, p1f;
  logic             p2a, p2b, p2c, p2d;
  logic             p1y, p2y;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic [VEC_W-1:0] vec_idx;
`ifdef IC7458_TESTER_FAIL_LOG_EN
  logic [VEC_W-1:0] first_fail_vec;
  logic [0:0]       first_fail_valid;
`endif

  // master: controller plus device side (drives start and responses)
  modport master (
    output start, p1y, p2y,
    input  p1a, p1b, p1c, p1d, p1e, p1f, p2a, p2b, p2c, p2d,
    input  busy, done, pass, err_count, vec_idx
`ifdef IC7458_TESTER_FAIL_LOG_EN
    , input first_fail_vec, first_fail_valid
`endif
  );

  // slave: the tester itself
  modport slave (
    input  start, p1y, p2y,
    output p1a, p1b, p1c, p1d, p1e, p1f, p2a, p2b, p2c, p2d,
    output busy, done, pass, err_count, vec_idx
`ifdef IC7458_TESTER_FAIL_LOG_EN
    , output first_fail_vec, first_fail_valid
`endif
  );
endinterface

// File: rtl/ic_7458_model.sv
// Golden 7458 model: 3+3 AND-OR section and 2+2 AND-OR section.
module ic_7458_model
  import ic_tester_pkg::*;
(
  input  logic [VEC_W-1:0] i_vec,
  output logic             o_exp1,
  output logic             o_exp2
);
  assign o_exp1 = (i_vec[0] & i_vec[1] & i_vec[2]) | (i_vec[3] & i_vec[4] & i_vec[5]);
  assign o_exp2 = (i_vec[6] & i_vec[7]) | (i_vec[8] & i_vec[9]);
endmodule

// File: rtl/ic_7458_tester.sv
// Exhaustive 7458 tester: walks all 1024 input vectors, holds each for
// SETTLE_CYCLES clocks, then compares both outputs in a one-clock CHECK.
// Optional first-fail log: define IC7458_TESTER_FAIL_LOG_EN.
module ic_7458_tester
  import ic_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  ic_7458_tester_if.slave  bus
);
  state_e           r_state, w_next;
  logic [VEC_W-1:0] r_vec;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_cnt;
  logic [VEC_W-1:0] w_stim;
  logic             w_exp1, w_exp2, w_mis, w_busy, w_settled, w_last;

  assign w_busy    = (r_state == APPLY) || (r_state == CHECK);
  // Stimulus stays on through CHECK so the sampled responses belong to r_vec.
  assign w_stim    = w_busy ? r_vec : '0;
  assign w_settled = (r_cnt == 4'(SETTLE_CYCLES - 1));
  assign w_last    = (r_vec == VEC_W'(NUM_VEC - 1));

  ic_7458_model u_model (
    .i_vec  (w_stim),
    .o_exp1 (w_exp1),
    .o_exp2 (w_exp2)
  );

  // One mismatch per vector regardless of how many outputs disagree.
  assign w_mis = (bus.p1y != w_exp1) || (bus.p2y != w_exp2);

  // Next-state logic; start is only honoured when not busy.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (bus.start) w_next = APPLY;
      APPLY:      if (w_settled) w_next = CHECK;
      CHECK:      w_next = w_last ? DONE : APPLY;
      default:    w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Vector index, settle counter and error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec <= '0;
      r_err <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: if (bus.start) begin
          r_vec <= '0;
          r_err <= '0;
          r_cnt <= '0;
        end
        APPLY: r_cnt <= w_settled ? 4'd0 : r_cnt + 4'd1;
        CHECK: begin
          r_err <= r_err + ERR_W'(w_mis);
          if (!w_last) r_vec <= r_vec + VEC_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef IC7458_TESTER_FAIL_LOG_EN
  logic [VEC_W-1:0] r_ff_vec;
  logic             r_ff_vld;

  // Latch the first failing vector of a run; later failures are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_vec <= '0;
      r_ff_vld <= 1'b0;
    end else if ((r_state == IDLE || r_state == DONE) && bus.start) begin
      r_ff_vec <= '0;
      r_ff_vld <= 1'b0;
    end else if (r_state == CHECK && w_mis && !r_ff_vld) begin
      r_ff_vec <= r_vec;
      r_ff_vld <= 1'b1;
    end
  end

  assign bus.first_fail_vec   = r_ff_vec;
  assign bus.first_fail_valid = r_ff_vld;
`endif

  assign {bus.p2d, bus.p2c, bus.p2b, bus.p2a} = w_stim[9:6];
  assign {bus.p1f, bus.p1e, bus.p1d, bus.p1c, bus.p1b, bus.p1a} = w_stim[5:0];
  assign bus.busy      = w_busy;
  assign bus.done      = (r_state == DONE);
  assign bus.pass      = (r_state == DONE) && (r_err == '0);
  assign bus.err_count = r_err;
  assign bus.vec_idx   = r_vec;
endmodule
